axi_blockram_stream: RTL and testbench

- Dual-access block RAM: AXI-lite-style word write/read port (narrow, byte-addressed) plus AXI-Stream master that plays out frames of programmable base/length at wide stream width.
- Successor to the fixed-32-beat stream RAM: programmable frame, true tready backpressure, byte strobes honoured, address wrap.
- Sits between register-bus slave and stream consumers (DAC/packetiser).

---
 rtl/axi_blockram_stream.sv | 214 +++++++++++++++++++++
 tb/tb_axi_blockram_stream.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_blockram_stream.sv
// Block RAM with a byte-addressed register port and an AXI-Stream frame player.
// Define STREAM_LOOP_EN to add the stop input and continuous frame looping.
module axi_blockram_stream #(
  parameter int    G_AXI_DATAWIDTH  = 32,
  parameter int    G_AXIS_DATAWIDTH = 64,
  parameter int    G_MEMDEPTH       = 1024,
  parameter int    G_LENWIDTH       = 16,
  parameter string G_INIT_FILE      = "",
  parameter int    G_ADDRWIDTH      = $clog2(G_MEMDEPTH),
  parameter int    G_BADDRWIDTH     = G_ADDRWIDTH + $clog2(G_AXIS_DATAWIDTH/8)
) (
  input  logic                          s_aclk,
  input  logic                          s_areset,
  input  logic                          start,
  input  logic [G_ADDRWIDTH-1:0]        base_addr,
  input  logic [G_LENWIDTH-1:0]         frame_len,
`ifdef STREAM_LOOP_EN
  input  logic                          stop,
`endif
  output logic                          busy,
  output logic                          done,
  output logic [G_AXIS_DATAWIDTH-1:0]   m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  input  logic                          rd,
  input  logic [G_BADDRWIDTH-1:0]       raddr,
  output logic [G_AXI_DATAWIDTH-1:0]    rdata,
  output logic                          rvalid,
  input  logic                          wr,
  input  logic [G_BADDRWIDTH-1:0]       waddr,
  input  logic [G_AXI_DATAWIDTH-1:0]    wdata,
  input  logic [G_AXI_DATAWIDTH/8-1:0]  wstrb
);

  localparam int PACK       = G_AXIS_DATAWIDTH / G_AXI_DATAWIDTH;
  localparam int AXI_BYTES  = G_AXI_DATAWIDTH / 8;
  localparam int AXIS_BYTES = G_AXIS_DATAWIDTH / 8;
  localparam int LANEW      = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int LANE_LSB   = $clog2(AXI_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t state, state_n;

  logic [AXIS_BYTES-1:0][7:0] mem [G_MEMDEPTH];
  logic [G_ADDRWIDTH-1:0]      wword, rword, addr_b;
  logic [AXIS_BYTES-1:0]       wbe;
  logic [AXIS_BYTES-1:0][7:0]  wdata_rep;
  logic [G_AXIS_DATAWIDTH-1:0] ram_q;
  logic                        ram_en;

  logic [G_ADDRWIDTH-1:0] base_q, issue_addr, cur_addr, cur_base;
  logic [G_LENWIDTH-1:0]  len_q, issue_cnt, cur_cnt, cur_len, cnt_inc;
  logic                   accept, issue, issue_end, rearm, room, pop;
  logic                   inflight, inflight_last, done_q;

  logic [G_AXIS_DATAWIDTH-1:0] fifo_d0, fifo_d1;
  logic                        fifo_l0, fifo_l1;
  logic [1:0]                  fifo_count, fill_wr;
  logic [2:0]                  fill_n;
  logic                        unused_addr_bits;

  assign wword     = waddr[G_BADDRWIDTH-1 -: G_ADDRWIDTH];
  assign rword     = raddr[G_BADDRWIDTH-1 -: G_ADDRWIDTH];
  assign wdata_rep = {PACK{wdata}};
  assign unused_addr_bits = ^{raddr, waddr};

  // Init-file contents are attached by the vendor RAM flow, not loaded here.
  if (G_INIT_FILE != "") begin : g_init_file
  end

  if (PACK > 1) begin : g_lanes
    logic [LANEW-1:0]                       wlane, rlane, rlane_q;
    logic [PACK-1:0][AXI_BYTES-1:0]         be_l;
    logic [PACK-1:0][G_AXI_DATAWIDTH-1:0]   rd_l;
    assign wlane = waddr[LANE_LSB +: LANEW];
    assign rlane = raddr[LANE_LSB +: LANEW];
    always_comb begin
      be_l        = '0;
      be_l[wlane] = wstrb;
    end
    assign wbe   = be_l;
    assign rd_l  = ram_q;
    assign rdata = rd_l[rlane_q];
    always_ff @(posedge s_aclk or posedge s_areset) begin
      if (s_areset)  rlane_q <= '0;
      else if (rd)   rlane_q <= rlane;
    end
  end else begin : g_single
    assign wbe   = wstrb;
    assign rdata = ram_q;
  end

  // Port A writes, port B reads; non-blocking update gives read-first.
  always_ff @(posedge s_aclk) begin
    if (wr) begin
      for (int unsigned b = 0; b < AXIS_BYTES; b++) begin
        if (wbe[b]) mem[wword][b] <= wdata_rep[b];
      end
    end
  end

  always_ff @(posedge s_aclk) begin
    if (ram_en) ram_q <= mem[addr_b];
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) rvalid <= 1'b0;
    else          rvalid <= rd;
  end

  // In IDLE the first read is issued straight from the start inputs.
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign accept    = (state == S_IDLE) && start && (frame_len != '0);
  assign cur_addr  = (state == S_IDLE) ? base_addr : issue_addr;
  assign cur_base  = (state == S_IDLE) ? base_addr : base_q;
  assign cur_cnt   = (state == S_IDLE) ? '0 : issue_cnt;
  assign cur_len   = (state == S_IDLE) ? frame_len : len_q;
  assign cnt_inc   = cur_cnt + G_LENWIDTH'(1);
  assign fill_n    = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign room      = fill_n < 3'd2;
  assign issue     = !rd && room && (accept || (state == S_RUN));
  assign issue_end = issue && (cnt_inc == cur_len);
  assign ram_en    = rd || issue;
  assign addr_b    = rd ? rword : cur_addr;

`ifdef STREAM_LOOP_EN
  logic stop_q;
  assign rearm = issue_end && !(stop_q || stop);
  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset)                         stop_q <= 1'b0;
    else if ((state == S_IDLE) || rearm)  stop_q <= 1'b0;
    else if (stop)                        stop_q <= 1'b1;
  end
`else
  assign rearm = 1'b0;
`endif

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = (issue_end && !rearm) ? S_DRAIN : S_RUN;
      S_RUN:   if (issue_end && !rearm) state_n = S_DRAIN;
      S_DRAIN: if (pop && fifo_l0) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      base_q        <= '0;
      len_q         <= '0;
      issue_addr    <= '0;
      issue_cnt     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue_end;
      done_q        <= pop && fifo_l0;
      if (accept) begin
        base_q     <= base_addr;
        len_q      <= frame_len;
        issue_addr <= base_addr;
        issue_cnt  <= '0;
      end
      if (issue) begin
        issue_addr <= rearm ? cur_base : cur_addr + G_ADDRWIDTH'(1);
        issue_cnt  <= rearm ? '0 : cnt_inc;
      end
    end
  end

  // Entry 0 is the head; it only moves on a pop, keeping tdata stable under stall.
  assign fill_wr = fifo_count - {1'b0, pop};
  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      fifo_count <= '0;
      fifo_d0    <= '0;
      fifo_d1    <= '0;
      fifo_l0    <= 1'b0;
      fifo_l1    <= 1'b0;
    end else begin
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
      if (pop) begin
        fifo_d0 <= fifo_d1;
        fifo_l0 <= fifo_l1;
      end
      if (inflight) begin
        if (fill_wr == 2'd0) begin
          fifo_d0 <= ram_q;
          fifo_l0 <= inflight_last;
        end else begin
          fifo_d1 <= ram_q;
          fifo_l1 <= inflight_last;
        end
      end
    end
  end

  assign m_axis_tvalid = fifo_count != 2'd0;
  assign m_axis_tdata  = fifo_d0;
  assign m_axis_tlast  = fifo_l0 && m_axis_tvalid;
  assign busy          = state != S_IDLE;
  assign done          = done_q;

endmodule

// File: tb/tb_axi_blockram_stream.sv
// Scoreboard bench for axi_blockram_stream: array-based RAM model, queued expected
// beats and read data, negedge monitor comparing every handshake.
module tb_axi_blockram_stream;
  localparam int AW = 32, SW = 64, DEPTH = 1024, LW = 16, ADDRW = 10, BADDRW = 13;

  logic              s_aclk = 1'b0, s_areset = 1'b1;
  logic              start = 1'b0, stop = 1'b0;
  logic [ADDRW-1:0]  base_addr = '0;
  logic [LW-1:0]     frame_len = '0;
  logic              busy, done, tvalid, tlast, rvalid;
  logic              tready = 1'b1;
  logic [SW-1:0]     tdata;
  logic              rd = 1'b0, wr = 1'b0;
  logic [BADDRW-1:0] raddr = '0, waddr = '0;
  logic [AW-1:0]     rdata, wdata = '0;
  logic [3:0]        wstrb = '0;

  axi_blockram_stream #(
    .G_AXI_DATAWIDTH(AW), .G_AXIS_DATAWIDTH(SW), .G_MEMDEPTH(DEPTH), .G_LENWIDTH(LW)
  ) dut (
    .s_aclk(s_aclk), .s_areset(s_areset), .start(start), .base_addr(base_addr),
    .frame_len(frame_len),
`ifdef STREAM_LOOP_EN
    .stop(stop),
`endif
    .busy(busy), .done(done), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tlast(tlast), .m_axis_tready(tready), .rd(rd), .raddr(raddr),
    .rdata(rdata), .rvalid(rvalid), .wr(wr), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
  );

  always #5 s_aclk = ~s_aclk;

  typedef struct packed { logic [SW-1:0] d; logic l; } beat_t;
  logic [SW-1:0] mem_m [DEPTH];
  beat_t         exp_beats[$];
  logic [AW-1:0] exp_rd[$];
  int checks = 0, errors = 0;
  int cyc = 0, first_acc = -1, last_acc = -1, beats_acc = 0;
  bit rand_tready = 1'b0;
  bit done_exp = 1'b0, stall_prev = 1'b0, rd_prev = 1'b0, prev_l = 1'b0;
  logic [SW-1:0] prev_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] model_read(input logic [BADDRW-1:0] a);
    int word = a / 8;
    int lane = (a / 4) % 2;
    return mem_m[word][lane*32 +: 32];
  endfunction

  task automatic model_write(input logic [BADDRW-1:0] a, input logic [AW-1:0] d,
                             input logic [3:0] s);
    int word = a / 8;
    int lane = (a / 4) % 2;
    for (int b = 0; b < 4; b++)
      if (s[b]) mem_m[word][lane*32 + b*8 +: 8] = d[b*8 +: 8];
  endtask

  // One register-bus cycle; read expectation is taken before the write lands.
  task automatic bus(input bit do_rd, input logic [BADDRW-1:0] ra, input bit do_wr,
                     input logic [BADDRW-1:0] wa, input logic [AW-1:0] wd,
                     input logic [3:0] ws);
    rd = do_rd; raddr = ra; wr = do_wr; waddr = wa; wdata = wd; wstrb = ws;
    if (do_rd) exp_rd.push_back(model_read(ra));
    if (do_wr) model_write(wa, wd, ws);
    @(posedge s_aclk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic start_frame(input int base, input int len);
    beat_t b;
    start = 1'b1; base_addr = ADDRW'(base); frame_len = LW'(len);
    for (int i = 0; i < len; i++) begin
      b.d = mem_m[(base + i) % DEPTH];
      b.l = (i == len - 1);
      exp_beats.push_back(b);
    end
    first_acc = -1;
    @(posedge s_aclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while ((exp_beats.size() != 0 || busy) && n < 2000) begin
      @(posedge s_aclk); #1;
      n++;
    end
    chk({name, "_timeout"}, 64'(n >= 2000), 64'd0);
    repeat (2) begin @(posedge s_aclk); #1; end
  endtask

  initial begin
    forever begin
      @(posedge s_aclk); #1;
      tready = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge s_aclk) begin : mon
    beat_t b;
    if (s_areset) begin
      done_exp = 1'b0; stall_prev = 1'b0; rd_prev = 1'b0;
    end else begin
      cyc++;
      chk("done", 64'(done), 64'(done_exp));
      done_exp = 1'b0;
      chk("rvalid", 64'(rvalid), 64'(rd_prev));
      if (rvalid) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdata: got unexpected response %h, expected none", rdata);
        end else chk("rdata", 64'(rdata), 64'(exp_rd.pop_front()));
      end
      if (stall_prev) begin
        chk("hold_tvalid", 64'(tvalid), 64'd1);
        chk("hold_tdata", tdata, prev_d);
        chk("hold_tlast", 64'(tlast), 64'(prev_l));
      end
      if (tvalid && tready) begin
        beats_acc++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (exp_beats.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got tdata %h, expected no beat", tdata);
        end else begin
          b = exp_beats.pop_front();
          chk("tdata", tdata, b.d);
          chk("tlast", 64'(tlast), 64'(b.l));
          if (b.l) done_exp = 1'b1;
        end
      end
      stall_prev = tvalid && !tready;
      prev_d = tdata;
      prev_l = tlast;
      rd_prev = rd;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge s_aclk);
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast",  64'(tlast),  64'd0);
    chk("rst_busy",   64'(busy),   64'd0);
    chk("rst_done",   64'(done),   64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    s_areset = 1'b0;
    @(posedge s_aclk); #1;

    // Known-zero RAM, then lane/strobe writes and read-first collision.
    for (int w = 0; w < DEPTH; w++) begin
      bus(0, '0, 1, BADDRW'(w*8), '0, 4'hF);
      bus(0, '0, 1, BADDRW'(w*8 + 4), '0, 4'hF);
    end
    bus(0, '0, 1, 13'h010, 32'hAABBCCDD, 4'hF);
    bus(0, '0, 1, 13'h014, 32'h11112222, 4'h3);
    bus(1, 13'h010, 0, '0, '0, '0);
    bus(1, 13'h014, 0, '0, '0, '0);
    bus(1, 13'h013, 1, 13'h010, 32'h12345678, 4'hF);
    bus(1, 13'h010, 0, '0, '0, '0);
    bus(0, '0, 0, '0, '0, '0);
    chk("rd_const_lo", 64'(model_read(13'h014)), 64'h00002222);

    // Words 0..7 hold their index; full-rate frame and latency.
    for (int w = 0; w < 8; w++) begin
      bus(0, '0, 1, BADDRW'(w*8), AW'(w), 4'hF);
      bus(0, '0, 1, BADDRW'(w*8 + 4), '0, 4'hF);
    end
    start_frame(0, 8);
    chk("tvalid_cycle1", 64'(tvalid), 64'd0);
    chk("busy_run", 64'(busy), 64'd1);
    @(posedge s_aclk); #1;
    chk("tvalid_cycle2", 64'(tvalid), 64'd1);
    chk("tdata_first", tdata, 64'd0);
    wait_frame("frame8");
    chk("throughput", 64'(last_acc - first_acc), 64'd7);
    chk("idle_after", 64'(busy), 64'd0);

    rand_tready = 1'b1;
    start_frame(0, 8);
    wait_frame("frame8_bp");

    // Wrap across the top of the RAM.
    for (int w = DEPTH - 2; w < DEPTH; w++) begin
      bus(0, '0, 1, BADDRW'(w*8), $urandom, 4'hF);
      bus(0, '0, 1, BADDRW'(w*8 + 4), $urandom, 4'hF);
    end
    start_frame(DEPTH - 2, 4);
    wait_frame("wrap");

    // Register reads every other cycle while a frame plays.
    for (int w = 0; w < 64; w++) begin
      bus(0, '0, 1, BADDRW'(w*8), $urandom, 4'hF);
      bus(0, '0, 1, BADDRW'(w*8 + 4), $urandom, 4'hF);
    end
    start_frame(10, 30);
    for (int n = 0; n < 500 && busy; n++) begin
      bus(1, BADDRW'($urandom_range(0, 64*8 - 1)), 0, '0, '0, '0);
      @(posedge s_aclk); #1;
    end
    wait_frame("frame_rd");

    start_frame(5, 0);
    chk("len0_busy", 64'(busy), 64'd0);
    @(posedge s_aclk); #1;
    chk("len0_busy2", 64'(busy), 64'd0);
    chk("len0_tvalid", 64'(tvalid), 64'd0);

    for (int f = 0; f < 3; f++) begin
      start_frame($urandom_range(0, DEPTH - 1), $urandom_range(1, 20));
      wait_frame("rand_frame");
    end

    // Asynchronous reset after the third beat.
    rand_tready = 1'b0;
    @(posedge s_aclk); #1;
    beats_acc = 0;
    start_frame(20, 8);
    for (int n = 0; n < 100 && beats_acc < 3; n++) begin
      @(negedge s_aclk); #2;
    end
    chk("reset_reach_beat3", 64'(beats_acc >= 3), 64'd1);
    s_areset = 1'b1;
    #1;
    chk("abort_tvalid", 64'(tvalid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    exp_beats.delete();
    repeat (2) @(posedge s_aclk);
    #1;
    s_areset = 1'b0;
    repeat (3) begin @(posedge s_aclk); #1; end
    start_frame(20, 2);
    wait_frame("after_reset");
    chk("beats_left", 64'(exp_beats.size()), 64'd0);
    chk("reads_left", 64'(exp_rd.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
